// File: rtl/decode_stage.sv
// ID stage of the 5-stage pipeline: 32x32 register file with write-through bypass,
// sign extension and main control decode. The ID/EX register is external.
module decode_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write_in,
   input  logic [31:0] instruccion,
   input  logic [31:0] WR,
   input  logic [31:0] WD,
   output logic [31:0] data1,
   output logic [31:0] data2,
   output logic [31:0] ext_sig,
   output logic        branch,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write_out,
   output logic        alu_src,
   output logic [5:0]  alu_op
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_BEQ   = 6'b000100,
      OP_BNE   = 6'b000101,
      OP_ADDI  = 6'b001000,
      OP_SLTI  = 6'b001010,
      OP_ANDI  = 6'b001100,
      OP_ORI   = 6'b001101,
      OP_LB    = 6'b100000,
      OP_LH    = 6'b100001,
      OP_LW    = 6'b100011,
      OP_LBU   = 6'b100100,
      OP_LHU   = 6'b100101,
      OP_SB    = 6'b101000,
      OP_SH    = 6'b101001,
      OP_SW    = 6'b101011
   } opcode_e;

   localparam logic [5:0] ALU_ADD = 6'b100000;
   localparam logic [5:0] ALU_SUB = 6'b100010;
   localparam logic [5:0] ALU_AND = 6'b100100;
   localparam logic [5:0] ALU_OR  = 6'b100101;
   localparam logic [5:0] ALU_SLT = 6'b101010;

   logic [31:0][31:0] regs_q, regs_d;
   logic [4:0]        wr_addr;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic              bypass_en;
   logic              unused_wr_hi;

   assign wr_addr      = WR[4:0];
   assign rs           = instruccion[25:21];
   assign rt           = instruccion[20:16];
   assign unused_wr_hi = &{1'b0, WR[31:5]};
   assign bypass_en    = reg_write_in && !reset;

   always_comb begin
      regs_d = regs_q;
      if (reg_write_in) begin
         regs_d[wr_addr] = WD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Write-through: a same-cycle write to the read address is visible immediately.
   always_comb begin
      data1 = regs_q[rs];
      data2 = regs_q[rt];
      if (bypass_en && (wr_addr == rs)) begin
         data1 = WD;
      end
      if (bypass_en && (wr_addr == rt)) begin
         data2 = WD;
      end
   end

   assign ext_sig = {{16{instruccion[15]}}, instruccion[15:0]};

   always_comb begin
      reg_dst       = 1'b0;
      alu_src       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write_out = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      branch        = 1'b0;
      alu_op        = '0;
      if (!reset) begin
         case (instruccion[31:26])
            OP_RTYPE: begin
               reg_dst       = 1'b1;
               reg_write_out = 1'b1;
               alu_op        = instruccion[5:0];
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
               alu_src       = 1'b1;
               mem_to_reg    = 1'b1;
               reg_write_out = 1'b1;
               mem_read      = 1'b1;
               alu_op        = ALU_ADD;
            end
            OP_SB, OP_SH, OP_SW: begin
               alu_src   = 1'b1;
               mem_write = 1'b1;
               alu_op    = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
               branch = 1'b1;
               alu_op = ALU_SUB;
            end
            OP_ADDI: begin
               alu_src       = 1'b1;
               reg_write_out = 1'b1;
               alu_op        = ALU_ADD;
            end
            OP_ANDI: begin
               alu_src       = 1'b1;
               reg_write_out = 1'b1;
               alu_op        = ALU_AND;
            end
            OP_ORI: begin
               alu_src       = 1'b1;
               reg_write_out = 1'b1;
               alu_op        = ALU_OR;
            end
            OP_SLTI: begin
               alu_src       = 1'b1;
               reg_write_out = 1'b1;
               alu_op        = ALU_SLT;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps then random instructions/writes/resets,
// checked against an array model of the register file and a table-driven decode.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset, reg_write_in;
   logic [31:0] instruccion, WR, WD;
   logic [31:0] data1, data2, ext_sig;
   logic        branch, mem_read, mem_write, mem_to_reg, reg_dst, reg_write_out, alu_src;
   logic [5:0]  alu_op;

   int unsigned passed = 0;
   int unsigned total  = 0;
   logic [31:0] model_regs [32];

   decode_stage dut (
      .clk(clk), .reset(reset), .reg_write_in(reg_write_in), .instruccion(instruccion),
      .WR(WR), .WD(WD), .data1(data1), .data2(data2), .ext_sig(ext_sig),
      .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .reg_dst(reg_dst), .reg_write_out(reg_write_out), .alu_src(alu_src), .alu_op(alu_op)
   );

   always #5 clk = ~clk;

   // {reg_dst, alu_src, mem_to_reg, reg_write_out, mem_read, mem_write, branch, alu_op}
   function automatic logic [12:0] exp_ctrl(input logic rst, input logic [31:0] ins);
      logic [5:0] op;
      op = ins[31:26];
      if (rst) return '0;
      if (op == 6'd0) return {7'b1001000, ins[5:0]};
      if (op inside {6'o40, 6'o41, 6'o43, 6'o44, 6'o45}) return {7'b0111100, 6'h20};
      if (op inside {6'o50, 6'o51, 6'o53}) return {7'b0100010, 6'h20};
      if (op inside {6'o04, 6'o05}) return {7'b0000001, 6'h22};
      case (op)
         6'o10: return {7'b0101000, 6'h20};
         6'o14: return {7'b0101000, 6'h24};
         6'o15: return {7'b0101000, 6'h25};
         6'o12: return {7'b0101000, 6'h2a};
         default: return '0;
      endcase
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (!reset && reg_write_in && WR[4:0] == a) return WD;
      return model_regs[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      logic [31:0] ext_exp;
      ext_exp = {{16{instruccion[15]}}, instruccion[15:0]};
      chk({tag, " data1"}, data1, exp_read(instruccion[25:21]));
      chk({tag, " data2"}, data2, exp_read(instruccion[20:16]));
      chk({tag, " ext_sig"}, ext_sig, ext_exp);
      chk({tag, " ctrl"}, {19'd0, reg_dst, alu_src, mem_to_reg, reg_write_out, mem_read,
                            mem_write, branch, alu_op}, {19'd0, exp_ctrl(reset, instruccion)});
   endtask

   task automatic step(input logic rst, input logic we, input logic [31:0] ins,
                       input logic [31:0] wr, input logic [31:0] wd, input string tag);
      reset = rst; reg_write_in = we; instruccion = ins; WR = wr; WD = wd;
      #2;
      check_all(tag);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) model_regs[i] = '0;
      end else if (we) begin
         model_regs[wr[4:0]] = wd;
      end
      #1;
   endtask

   initial begin
      logic [5:0]  ops [16];
      logic [31:0] ins;
      for (int i = 0; i < 32; i++) model_regs[i] = 'x;
      ops = '{6'o00, 6'o40, 6'o41, 6'o43, 6'o44, 6'o45, 6'o50, 6'o51,
              6'o53, 6'o04, 6'o05, 6'o10, 6'o14, 6'o15, 6'o12, 6'o77};
      reset = 1'b1; reg_write_in = 1'b0; instruccion = '0; WR = '0; WD = '0;
      @(negedge clk);

      step(1'b1, 1'b0, 32'h8001_0001, 32'd0, 32'd0, "reset");
      step(1'b0, 1'b1, 32'h0000_0001, 32'd0, 32'hAAAA_AAAA, "write0_bypass");
      step(1'b0, 1'b0, 32'h0000_0001, 32'd0, 32'd0, "rtype_r0");
      step(1'b0, 1'b1, 32'h0000_0001, 32'd1, 32'h5555_5555, "write1");
      step(1'b0, 1'b0, 32'h8001_0001, 32'd0, 32'd0, "load");
      step(1'b0, 1'b0, 32'hA000_0001, 32'd0, 32'd0, "store");
      step(1'b0, 1'b0, 32'h1000_0001, 32'd0, 32'd0, "branch");
      step(1'b0, 1'b0, 32'h2000_8000, 32'd0, 32'd0, "signext");
      step(1'b0, 1'b1, 32'h0060_0000, 32'hFFFF_FFE3, 32'h1234_5678, "bypass_rs3_wr_hi");
      step(1'b0, 1'b0, 32'h0060_0000, 32'd0, 32'd0, "read_r3");
      step(1'b0, 1'b1, 32'h0000_0000, 32'd31, 32'hDEAD_BEEF, "write31");
      step(1'b1, 1'b1, 32'h8C1F_0004, 32'd5, 32'hCAFE_F00D, "reset_mid");
      for (int unsigned r = 0; r < 32; r++) begin
         step(1'b0, 1'b0, {6'd0, r[4:0], r[4:0], 16'h0020}, 32'd0, 32'd0, "post_reset_read");
      end

      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         ins[31:26] = ops[$urandom_range(15)];
         step(($urandom_range(40) == 0), $urandom_range(1) == 1, ins,
              ($urandom_range(3) == 0) ? {27'd0, ins[25:21]} : $urandom, $urandom, "random");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode (ID) stage of the 5-stage MIPS-style pipeline.
- Contains the 32x32 general register file, which is written back from the WB stage.
- Combinationally produces:
  - the two source operands,
  - the sign-extended immediate,
  - the main control signals consumed by the EX/MEM/WB stages.
- The ID/EX pipeline register is external to this block.

Parameters:
- None. Data width is fixed at 32 bits and the register file at 32 entries.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- reg_write_in  input  1  write-back enable from the WB stage
- instruccion  input  32  instruction word from the IF/ID register
- WR  input  32  write-back register number; only WR[4:0] is used, upper bits are ignored
- WD  input  32  write-back data
- data1  output  32  register file read of rs = instruccion[25:21]
- data2  output  32  register file read of rt = instruccion[20:16]
- ext_sig  output  32  sign-extended instruccion[15:0]
- branch  output  1  conditional branch instruction
- mem_read  output  1  data-memory read (load)
- mem_write  output  1  data-memory write (store)
- mem_to_reg  output  1  write-back source: 1 = memory, 0 = ALU
- reg_dst  output  1  destination select: 1 = rd [15:11], 0 = rt [20:16]
- reg_write_out  output  1  instruction writes a register
- alu_src  output  1  ALU operand B select: 1 = ext_sig, 0 = data2
- alu_op  output  6  ALU function code

Behaviour:
- Register file:
  - 32 entries x 32 bits; all entries, including register 0, are ordinary writable storage.
  - Write: on rising clk, if reset=0 and reg_write_in=1, then reg[WR[4:0]] <= WD.
  - Reset: on rising clk with reset=1, all 32 registers clear to 0; a write requested in the same cycle is ignored.
  - Reads are combinational.
  - Write-through bypass: if reg_write_in=1 and WR[4:0] equals the read address, that output shows WD in the same cycle. Bypass is disabled while reset=1.
- ext_sig = {16{instruccion[15]}, instruccion[15:0]}; purely combinational.
- Control: purely combinational decode of opcode = instruccion[31:26]. Signal order below is reg_dst, alu_src, mem_to_reg, reg_write_out, mem_read, mem_write, branch, then alu_op.
  - 000000 R-type: 1, 0, 0, 1, 0, 0, 0; alu_op = instruccion[5:0] (funct).
  - Loads 100000, 100001, 100011, 100100, 100101: 0, 1, 1, 1, 1, 0, 0; alu_op = 100000 (add).
  - Stores 101000, 101001, 101011: 0, 1, 0, 0, 0, 1, 0; alu_op = 100000.
  - Branches 000100 (beq), 000101 (bne): 0, 0, 0, 0, 0, 0, 1; alu_op = 100010 (sub).
  - Immediate ALU: 0, 1, 0, 1, 0, 0, 0, with alu_op by opcode:
    - 001000 addi -> 100000
    - 001100 andi -> 100100
    - 001101 ori -> 100101
    - 001010 slti -> 101010
  - Any other opcode: all control outputs 0, alu_op = 000000 (bubble).
- While reset=1, all control outputs are forced to 0 regardless of instruccion.
- After reset is released, data1 and data2 read 0 until the corresponding registers are written.
- The block has no latency of its own: outputs are valid in the same cycle the inputs are applied, and are captured by the downstream ID/EX register.

Test Plan:
- Reset, then write: assert reset for one edge; apply reg_write_in=1, WR=0, WD=AAAAAAAA, rising edge; then instruccion=00000001 (R-type, rs=rt=0) -> data1=data2=AAAAAAAA, reg_dst=1, reg_write_out=1, alu_src=0, alu_op=000001.
- Second write: reg_write_in=1, WR=1, WD=55555555, rising edge; then instruccion=80010001 (load, rs=0, rt=1) -> data1=AAAAAAAA, data2=55555555, ext_sig=00000001, mem_read=1, mem_to_reg=1, alu_src=1, reg_write_out=1, alu_op=100000.
- Store: instruccion=A0000001 -> mem_write=1, alu_src=1, reg_write_out=0, mem_read=0, ext_sig=00000001.
- Branch: instruccion=10000001 -> branch=1, alu_op=100010, all other controls 0.
- Sign extension and bypass:
  - instruccion[15:0]=8000 -> ext_sig=FFFF8000.
  - reg_write_in=1, WR=3, WD=12345678 with rs=3 -> data1=12345678 before the clock edge.
- Reset mid-operation: assert reset with a pending write and a load instruction -> all control outputs are 0; after the edge every register reads 0 and the pending write is not performed.
